// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared state encoding and width constants for the parallel readout reader
package readout_pkg;

    localparam int RO_ADDR_W = 24;
    localparam int RO_DATA_W = 16;
    localparam int RO_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } rd_state_t;

endpackage

// File: rtl/parallel_mem_reader.sv
// rtl/parallel_mem_reader.sv - walks an address range on the processor readout port and streams the words out
module parallel_mem_reader
    import readout_pkg::*;
#(
    parameter int ADDR_W       = RO_ADDR_W,
    parameter int DATA_W       = RO_DATA_W,
    parameter int CNT_W        = RO_CNT_W,
    parameter int READ_LATENCY = 1          // 1..7 edges from address sample to valid q
) (
    input  logic              clk,             // single rising-edge clock
    input  logic              rst,             // synchronous, active low
    input  logic              start,           // one-cycle command, honoured only in IDLE
    input  logic [ADDR_W-1:0] base_addr,       // first address, latched on accepted start
    input  logic [CNT_W-1:0]  word_count,      // words to read, latched on accepted start
    input  logic              abort,           // cancel, effective in any non-IDLE state
    output logic [ADDR_W-1:0] parallelAddress, // registered address to the readout port
    input  logic [DATA_W-1:0] q,               // readout data from the processor
    output logic [DATA_W-1:0] out_data,        // captured word
    output logic              out_valid,       // out_data is valid
    input  logic              out_ready,       // consumer accepts the word
    output logic              busy,            // high outside IDLE
    output logic              done             // one-cycle pulse at range completion
);

    rd_state_t         state;
    rd_state_t         state_n;
    logic [ADDR_W-1:0] cur;
    logic [CNT_W-1:0]  rem;
    logic [2:0]        lat_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = (word_count == '0) ? DONE : ADDR;
                end
            end
            ADDR: state_n = WAIT;
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_n = (rem == CNT_W'(1)) ? DONE : ADDR;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort overrides everything, including a handshake in the same cycle
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any combinational path from q or out_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur             <= '0;
            rem             <= '0;
            lat_cnt         <= '0;
            parallelAddress <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
            out_valid <= (state_n == HOLD);
            case (state)
                IDLE: begin
                    if (state_n == ADDR) begin
                        cur             <= base_addr;
                        rem             <= word_count;
                        parallelAddress <= base_addr;
                    end
                end
                ADDR: begin
                    if (state_n == WAIT) begin
                        lat_cnt <= 3'(READ_LATENCY);
                    end
                end
                WAIT: begin
                    if (lat_cnt != 3'd0) begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                    if (state_n == HOLD) begin
                        out_data <= q;
                    end
                end
                HOLD: begin
                    // address wraps naturally at 2^ADDR_W
                    if (state_n == ADDR) begin
                        cur             <= cur + ADDR_W'(1);
                        rem             <= rem - CNT_W'(1);
                        parallelAddress <= cur + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
